gen_scheduler: RTL and testbench



---
 rtl/gen_scheduler.sv | 129 ++++++++++++
 tb/tb_gen_scheduler.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gen_scheduler.sv
// Generation sequencer for the Game-of-Life grid: seed load window, run/pause/step
// mode, interval timer, and arbitration between cursor edits and generation updates.
module gen_scheduler #(
    parameter int unsigned BASE_WAIT   = 'h4_0000,
    parameter int unsigned CNT_W       = 30,
    parameter int unsigned GEN_W       = 16,
    parameter int unsigned LOAD_CYCLES = 100
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_btn,
    input  logic             select_btn,
    input  logic [3:0]       speed,
    input  logic             edit_set,
    input  logic             edit_clr,
    output logic             gen_en,
    output logic             load_pattern,
    output logic             edit_en,
    output logic             edit_val,
    output logic             running,
    output logic [GEN_W-1:0] gen_count
);

    localparam int unsigned LOAD_W = $clog2(LOAD_CYCLES + 1);

    typedef enum logic [1:0] {ST_LOAD, ST_PAUSE, ST_RUN, ST_STEP} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  timer_q, timer_d;
    logic [CNT_W-1:0]  thresh;
    logic [LOAD_W-1:0] load_cnt_q, load_cnt_d;
    logic [GEN_W-1:0]  gen_count_q, gen_count_d;
    logic              pending_q, pending_d;
    logic              start_q, select_q;
    logic              load_pattern_q, running_q;
    logic              start_edge, select_edge, leave_run, tick, req, edit_req;

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        load_cnt_d  = load_cnt_q;
        pending_d   = pending_q;
        gen_count_d = gen_count_q;

        start_edge  = start_btn & ~start_q;
        select_edge = select_btn & ~select_q;
        thresh      = CNT_W'(BASE_WAIT) >> speed;
        leave_run   = (state_q == ST_RUN) && start_edge;
        // The RUN->PAUSE cycle issues nothing, including a deferred generation.
        tick        = (state_q == ST_RUN) && (speed != 4'd0) && (timer_q >= thresh) && !leave_run;
        req         = !leave_run && (tick || (state_q == ST_STEP) || pending_q);
        edit_req    = (edit_set | edit_clr) && (state_q != ST_LOAD);

        gen_en      = req && !edit_req && !reset;
        edit_en     = edit_req;
        edit_val    = edit_set & edit_req;

        if (gen_en) begin
            gen_count_d = gen_count_q + GEN_W'(1);
        end

        // At most one generation is deferred behind an edit.
        if (gen_en || leave_run) begin
            pending_d = 1'b0;
        end else if (req && edit_req) begin
            pending_d = 1'b1;
        end

        case (state_q)
            ST_LOAD: begin
                load_cnt_d = load_cnt_q + LOAD_W'(1);
                if (load_cnt_q == LOAD_W'(LOAD_CYCLES - 1)) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (start_edge) begin
                    state_d = ST_RUN;
                    timer_d = '0;
                end else if (select_edge) begin
                    state_d = ST_STEP;
                end
            end
            ST_RUN: begin
                if (leave_run) begin
                    state_d = ST_PAUSE;
                end else if (speed == 4'd0 || tick) begin
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end
            ST_STEP: begin
                if (gen_en) begin
                    state_d = ST_PAUSE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_LOAD;
            timer_q        <= '0;
            load_cnt_q     <= '0;
            gen_count_q    <= '0;
            pending_q      <= 1'b0;
            start_q        <= 1'b0;
            select_q       <= 1'b0;
            load_pattern_q <= 1'b1;
            running_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            load_cnt_q     <= load_cnt_d;
            gen_count_q    <= gen_count_d;
            pending_q      <= pending_d;
            start_q        <= start_btn;
            select_q       <= select_btn;
            load_pattern_q <= (state_d == ST_LOAD);
            running_q      <= (state_d == ST_RUN);
        end
    end

    assign load_pattern = load_pattern_q;
    assign running      = running_q;
    assign gen_count    = gen_count_q;

endmodule

// File: tb/tb_gen_scheduler.sv
// Self-checking bench for gen_scheduler: vector table, directed corner sequences,
// and random stimulus compared every cycle against a behavioural mode/interval model.
module tb_gen_scheduler;

    logic        clk = 1'b0;
    logic        reset, start_btn, select_btn, edit_set, edit_clr;
    logic [3:0]  speed;
    logic        gen_en, load_pattern, edit_en, edit_val, running;
    logic [15:0] gen_count;

    always #5 clk = ~clk;

    gen_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .start_btn    (start_btn),
        .select_btn   (select_btn),
        .speed        (speed),
        .edit_set     (edit_set),
        .edit_clr     (edit_clr),
        .gen_en       (gen_en),
        .load_pattern (load_pattern),
        .edit_en      (edit_en),
        .edit_val     (edit_val),
        .running      (running),
        .gen_count    (gen_count)
    );

    localparam int M_LOAD = 0, M_PAUSE = 1, M_RUN = 2, M_STEP = 3;

    int checks = 0;
    int errors = 0;

    // Reference model: operating mode, cycles spent loading, cycles elapsed since the
    // interval last restarted, one-deep deferred generation flag, generation total.
    int m_mode = M_LOAD;
    int m_load = 0;
    int m_elapsed = 0;
    int m_count = 0;
    bit m_pending = 0;
    bit m_st_prev = 0;
    bit m_se_prev = 0;

    bit obs_gen, obs_load, obs_een, obs_eval, obs_run;
    int obs_count;

    typedef struct {
        bit s;
        bit c;
        bit exp_en;
        bit exp_val;
    } vec_t;
    vec_t tbl [4];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, compare settled outputs with the model, advance the model.
    task automatic cycle(input bit r, input bit st, input bit se, input bit [3:0] sp,
                         input bit es, input bit ec);
        bit st_e, se_e, run, leaving, tick, edit, req, gen;
        int thresh;
        @(negedge clk);
        reset = r; start_btn = st; select_btn = se; speed = sp; edit_set = es; edit_clr = ec;
        #1;
        obs_gen = gen_en; obs_load = load_pattern; obs_een = edit_en;
        obs_eval = edit_val; obs_run = running; obs_count = int'(gen_count);
        st_e = st && !m_st_prev;
        se_e = se && !m_se_prev;
        if (r) begin
            check("gen_en_during_reset", int'(obs_gen), 0);
            m_mode = M_LOAD; m_load = 0; m_elapsed = 0; m_count = 0;
            m_pending = 0; m_st_prev = 0; m_se_prev = 0;
        end else begin
            run     = (m_mode == M_RUN);
            leaving = run && st_e;
            thresh  = 'h40000 >> sp;
            tick    = run && (sp != 0) && (m_elapsed >= thresh) && !leaving;
            edit    = (es || ec) && (m_mode != M_LOAD);
            req     = !leaving && (tick || m_mode == M_STEP || m_pending);
            gen     = req && !edit;
            check("gen_en", int'(obs_gen), int'(gen));
            check("load_pattern", int'(obs_load), int'(m_mode == M_LOAD));
            check("running", int'(obs_run), int'(run));
            check("edit_en", int'(obs_een), int'(edit));
            check("edit_val", int'(obs_eval), int'(edit && es));
            check("gen_count", obs_count, m_count);
            if (gen) m_count = (m_count + 1) % 65536;
            if (gen || leaving) m_pending = 0;
            else if (req && edit) m_pending = 1;
            case (m_mode)
                M_LOAD: begin
                    m_load++;
                    if (m_load == 100) m_mode = M_PAUSE;
                end
                M_PAUSE: begin
                    if (st_e) begin m_mode = M_RUN; m_elapsed = 0; end
                    else if (se_e) m_mode = M_STEP;
                end
                M_RUN: begin
                    if (leaving) m_mode = M_PAUSE;
                    else if (sp == 0 || tick) m_elapsed = 0;
                    else m_elapsed++;
                end
                default: if (gen) m_mode = M_PAUSE;
            endcase
            m_st_prev = st;
            m_se_prev = se;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, g, e, first, second;
        bit rst, st, se, es, ec;
        bit [3:0] sp;

        tbl[0] = '{s: 0, c: 0, exp_en: 0, exp_val: 0};
        tbl[1] = '{s: 1, c: 0, exp_en: 1, exp_val: 1};
        tbl[2] = '{s: 0, c: 1, exp_en: 1, exp_val: 0};
        tbl[3] = '{s: 1, c: 1, exp_en: 1, exp_val: 1};

        reset = 1; start_btn = 0; select_btn = 0; speed = 0; edit_set = 0; edit_clr = 0;
        repeat (3) cycle(1, 0, 0, 0, 0, 0);

        // Load window with button and edit noise that must all be ignored
        n = 0;
        for (int i = 0; i < 120; i++) begin
            cycle(0, (i < 90) && (i % 2 == 1), (i < 90) && (i % 3 == 0), 4,
                  (i % 5 == 0), (i % 7 == 0));
            if (obs_load) n++;
            if (i == 0) begin
                check("reset_load_pattern", int'(obs_load), 1);
                check("reset_gen_count", obs_count, 0);
                check("reset_running", int'(obs_run), 0);
            end
            if (i == 35) check("load_edit_both", int'(obs_een), 0);
        end
        check("load_len", n, 100);
        check("after_load_running", int'(obs_run), 0);
        check("after_load_count", obs_count, 0);

        foreach (tbl[t]) begin
            cycle(0, 0, 0, 4, tbl[t].s, tbl[t].c);
            check("vec_edit_en", int'(obs_een), int'(tbl[t].exp_en));
            check("vec_edit_val", int'(obs_eval), int'(tbl[t].exp_val));
            check("vec_gen_en", int'(obs_gen), 0);
        end

        // Single step: long select press gives exactly one generation
        g = 0;
        repeat (5) begin cycle(0, 0, 1, 4, 0, 0); g += int'(obs_gen); end
        repeat (1000) begin cycle(0, 0, 0, 4, 0, 0); g += int'(obs_gen); end
        check("step_pulses", g, 1);
        check("step_count", obs_count, 1);
        check("step_running", int'(obs_run), 0);

        // Run at speed 4: period 0x4001
        cycle(0, 1, 0, 4, 0, 0);
        g = 0; first = -1; second = -1;
        for (int k = 0; k < 3 * 'h4001; k++) begin
            cycle(0, 0, 0, 4, 0, 0);
            if (obs_gen) begin
                if (g == 0) first = k;
                else if (g == 1) second = k;
                g++;
            end
        end
        check("run_pulses", g, 3);
        check("run_first_tick", first, 'h4000);
        check("run_period", second - first, 'h4001);
        cycle(0, 0, 0, 4, 0, 0);
        check("run_count", obs_count, 4);

        g = 0;
        repeat (500) begin cycle(0, 0, 0, 0, 0, 0); g += int'(obs_gen); end
        check("speed0_pulses", g, 0);
        check("speed0_running", int'(obs_run), 1);

        // Edit held across two ticks at speed 15: exactly one deferred generation
        g = 0; e = 0;
        repeat (20) begin
            cycle(0, 0, 0, 15, 1, 0);
            g += int'(obs_gen);
            e += int'(obs_een && obs_eval);
        end
        check("edit_hold_gen", g, 0);
        check("edit_hold_edits", e, 20);
        cycle(0, 0, 0, 15, 0, 0);
        check("deferred_gen", int'(obs_gen), 1);
        g = 0;
        repeat (5) begin cycle(0, 0, 0, 15, 0, 0); g += int'(obs_gen); end
        check("no_stacked_gen", g, 0);

        // Reset while a generation is pending
        repeat (4) cycle(0, 0, 0, 15, 0, 1);
        cycle(1, 0, 0, 15, 0, 1);
        g = 0; n = 0;
        for (int i = 0; i < 100; i++) begin
            cycle(0, 0, 0, 15, 0, 0);
            if (i == 0) begin
                check("mid_reset_load", int'(obs_load), 1);
                check("mid_reset_count", obs_count, 0);
                check("mid_reset_running", int'(obs_run), 0);
            end
            g += int'(obs_gen);
            n += int'(obs_load);
        end
        check("mid_reset_gen", g, 0);
        check("mid_reset_load_len", n, 100);

        // Random buttons, speeds, edits and occasional resets
        st = 0; se = 0; sp = 15;
        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(0, 99) < 3) st = ~st;
            if ($urandom_range(0, 99) < 4) se = ~se;
            if ($urandom_range(0, 63) == 0) begin
                case ($urandom_range(0, 5))
                    0: sp = 0;
                    1: sp = 11;
                    2: sp = 12;
                    3: sp = 13;
                    4: sp = 14;
                    default: sp = 15;
                endcase
            end
            es = ($urandom_range(0, 99) < 15);
            ec = ($urandom_range(0, 99) < 15);
            rst = ($urandom_range(0, 1999) == 0);
            cycle(rst, st, se, sp, es, ec);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
